quiz_host: RTL and testbench
============================

QUIZ_HOST -- requirements
Module: quiz_host

Interface
REQ-001 Parameter ANSWER_SECS, default 9: answer time limit in seconds, range 1..9.
REQ-002 Parameter BEEP_CYCLES, default 50_000_000: beep duration in clock cycles on the result.
REQ-003 clock  in  1  system clock; all state updates on rising edge.
REQ-004 reset  in  1  asynchronous, active-low reset.
REQ-005 start  in  1  host button, synchronous level; only its rising edge acts.
REQ-006 chose  in  3  one-hot from the contestant lockout block; 000 means no contestant.
REQ-007 tick  in  1  one-cycle pulse, 1 Hz.
REQ-008 judge_ok, judge_ng  in  1 each  host verdict pulses.
REQ-009 arm  out  1  enables contestant lockout; high only in ARMED.
REQ-010 clear  out  1  one-cycle pulse that clears the lockout latch.
REQ-011 beep  out  1  buzzer drive.
REQ-012 bs0, bs1  out  7 each  active-low segments {g,f,e,d,c,b,a}; 7'h7F is blank.

Function
REQ-013 FSM states: IDLE, ARMED, ANSWER, RESULT.
REQ-014 IDLE: a start rising edge moves to ARMED next cycle.
REQ-015 ARMED: chose != 000 moves to ANSWER, latches the id, and loads the timer with ANSWER_SECS.
REQ-016 Multiple chose bits set in the same cycle: the lowest index wins.
REQ-017 ARMED: a start rising edge aborts to IDLE and pulses clear; this takes priority over chose.
REQ-018 ANSWER: each tick decrements the timer; a tick at timer==1 counts as judge_ng.
REQ-019 ANSWER: judge_ok adds 1 to the score of the latched id, saturating at 9, then moves to RESULT.
REQ-020 ANSWER: judge_ng leaves the score unchanged (see REQ-031) and moves to RESULT.
REQ-021 judge_ok and judge_ng high in the same cycle: both are ignored and the state is held; a tick in that cycle still counts.
REQ-022 judge_ok coincident with a timeout tick: judge_ok wins.
REQ-023 RESULT: beep is high for exactly BEEP_CYCLES cycles, then the FSM enters IDLE; clear pulses on that IDLE-entry cycle.
REQ-024 Judge inputs outside ANSWER are ignored; start is ignored in ANSWER and RESULT.
REQ-025 bs0 shows the latched id as digit 1..3 in ANSWER and RESULT; otherwise blank.
REQ-026 bs1 shows the remaining seconds in ANSWER, the latched id's score in RESULT, and blank otherwise.
REQ-027 Display outputs are registered: one cycle of latency from the state/value change.

Reset
REQ-028 Reset asserted: state=IDLE; all three scores 0; timer 0; arm=0, clear=0, beep=0; bs0=bs1=7'h7F.
REQ-029 Reset mid-operation takes effect immediately; scores are not preserved.
REQ-030 On release, the first start edge is recognised only if start rises after reset deasserts.

Configuration
REQ-031 Macro QUIZ_PENALTY_EN: when defined, judge_ng (including timeout) subtracts 1 from the latched score, floored at 0; when undefined, judge_ng leaves the score unchanged.

Structure
REQ-032 Shared package quiz_defs holds: state encodings, the blank-segment constant, and the score width (4 bits).
REQ-033 A sub-module seg7_decode (4-bit value plus blank in, 7-bit active-low out) is instantiated twice.

Verification
REQ-034 start edge, then chose=010, then judge_ok -> arm high in ARMED; bs0 shows "2"; bs1 shows 1 in RESULT; beep held BEEP_CYCLES; clear pulse on IDLE entry.
REQ-035 chose=011 in ARMED -> id 1 latched; bs0 shows "1".
REQ-036 With ANSWER_SECS=3, no verdict, 3 ticks -> bs1 shows 3,2,1, then RESULT; score unchanged without the macro, score 0 (floored) with QUIZ_PENALTY_EN.
REQ-037 Ten judge_ok rounds for contestant 3 -> score saturates at 9.
REQ-038 judge_ok and judge_ng together in ANSWER -> state held; a later single judge_ok is accepted.
REQ-039 reset low during RESULT while beep is high -> beep=0 and blank displays immediately; all scores 0 after release.

Source files
------------

// File: rtl/quiz_host_pkg.sv
// Shared definitions for the quiz host: FSM state encoding, the blank segment
// pattern, the score width and the contestant-priority helper.
package quiz_defs;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ARMED  = 2'd1,
    ST_ANSWER = 2'd2,
    ST_RESULT = 2'd3
  } state_e;

  localparam logic [6:0] SEG_BLANK = 7'h7F;

  localparam int SCORE_W = 4;
  typedef logic [SCORE_W-1:0] score_t;
  localparam score_t SCORE_MAX = score_t'(9);

  // Contestant id 1..3 from the one-hot lockout vector; lowest index wins.
  function automatic logic [1:0] lowest_id(input logic [2:0] chose);
    logic [1:0] id;
    id = 2'd0;
    if (chose[0]) begin
      id = 2'd1;
    end else if (chose[1]) begin
      id = 2'd2;
    end else if (chose[2]) begin
      id = 2'd3;
    end
    return id;
  endfunction

endpackage

// File: rtl/quiz_host_if.sv
// Panel-side signal bundle of the quiz host: host buttons, lockout vector,
// 1 Hz tick and verdicts in; lockout control, buzzer and two digits out.
interface quiz_host_if;

  logic       start;
  logic [2:0] chose;
  logic       tick;
  logic       judge_ok;
  logic       judge_ng;
  logic       arm;
  logic       clear;
  logic       beep;
  logic [6:0] bs0;
  logic [6:0] bs1;

  modport master (
    output start, chose, tick, judge_ok, judge_ng,
    input  arm, clear, beep, bs0, bs1
  );

  modport slave (
    input  start, chose, tick, judge_ok, judge_ng,
    output arm, clear, beep, bs0, bs1
  );

endinterface

// File: rtl/quiz_host_seg7.sv
// Decimal digit to active-low 7-segment pattern {g,f,e,d,c,b,a}; values above
// 9 and an asserted blank both produce an unlit digit.
module seg7_decode
  import quiz_defs::*;
(
  input  logic [3:0] value_i,
  input  logic       blank_i,
  output logic [6:0] seg_o
);

  always_comb begin
    seg_o = SEG_BLANK;
    if (!blank_i) begin
      case (value_i)
        4'd0:    seg_o = 7'h40;
        4'd1:    seg_o = 7'h79;
        4'd2:    seg_o = 7'h24;
        4'd3:    seg_o = 7'h30;
        4'd4:    seg_o = 7'h19;
        4'd5:    seg_o = 7'h12;
        4'd6:    seg_o = 7'h02;
        4'd7:    seg_o = 7'h78;
        4'd8:    seg_o = 7'h00;
        4'd9:    seg_o = 7'h10;
        default: seg_o = SEG_BLANK;
      endcase
    end
  end

endmodule

// File: rtl/quiz_host.sv
// Quiz host controller: arms the lockout, times the answer, keeps three scores
// and drives buzzer plus two digits. Define QUIZ_PENALTY_EN to deduct on a miss.
module quiz_host
  import quiz_defs::*;
#(
  parameter int unsigned ANSWER_SECS = 9,
  parameter int unsigned BEEP_CYCLES = 50_000_000
) (
  input logic        clock_i,
  input logic        reset_ni,
  quiz_host_if.slave bus
);

  localparam int BEEP_W = (BEEP_CYCLES > 1) ? $clog2(BEEP_CYCLES) : 1;
  localparam logic [BEEP_W-1:0] BEEP_LAST   = BEEP_W'(BEEP_CYCLES - 1);
  localparam logic [3:0]        ANSWER_INIT = 4'(ANSWER_SECS);

  state_e            state_q, state_d;
  logic              start_q;
  logic [1:0]        id_q, id_d;
  logic [3:0]        timer_q, timer_d;
  logic [BEEP_W-1:0] beep_cnt_q, beep_cnt_d;
  logic              clear_q, clear_d;
  logic [6:0]        bs0_q, bs1_q;
  logic [6:0]        bs0_d, bs1_d;

  logic              start_edge;
  logic              verdict_ok;
  logic              verdict_ng;
  logic              timeout;
  logic              score_inc;
  logic              score_dec;
  score_t [2:0]      score_all;
  score_t            latched_score;
  logic              show_id;
  logic [3:0]        bs1_value;

  assign start_edge = bus.start & ~start_q;
  // Contradictory verdicts cancel each other; the tick is still honoured.
  assign verdict_ok = bus.judge_ok & ~bus.judge_ng;
  assign verdict_ng = bus.judge_ng & ~bus.judge_ok;

  always_comb begin
    state_d    = state_q;
    id_d       = id_q;
    timer_d    = timer_q;
    beep_cnt_d = beep_cnt_q;
    clear_d    = 1'b0;
    score_inc  = 1'b0;
    score_dec  = 1'b0;
    timeout    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start_edge) begin
          state_d = ST_ARMED;
        end
      end

      ST_ARMED: begin
        if (start_edge) begin
          state_d = ST_IDLE;
          clear_d = 1'b1;
        end else if (bus.chose != 3'b000) begin
          id_d    = lowest_id(bus.chose);
          timer_d = ANSWER_INIT;
          state_d = ST_ANSWER;
        end
      end

      ST_ANSWER: begin
        if (bus.tick && (timer_q != 4'd0)) begin
          timer_d = timer_q - 4'd1;
          timeout = (timer_q == 4'd1);
        end
        if (verdict_ok) begin
          score_inc  = 1'b1;
          beep_cnt_d = '0;
          state_d    = ST_RESULT;
        end else if (verdict_ng || timeout) begin
`ifdef QUIZ_PENALTY_EN
          score_dec  = 1'b1;
`endif
          beep_cnt_d = '0;
          state_d    = ST_RESULT;
        end
      end

      ST_RESULT: begin
        if (beep_cnt_q == BEEP_LAST) begin
          state_d = ST_IDLE;
          clear_d = 1'b1;
        end else begin
          beep_cnt_d = beep_cnt_q + 1'b1;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // One saturating score register per contestant, selected by the latched id.
  for (genvar gi = 0; gi < 3; gi++) begin : g_score
    score_t score_q;
    logic   selected;

    assign selected = (id_q == 2'(gi + 1));

    always_ff @(posedge clock_i or negedge reset_ni) begin
      if (!reset_ni) begin
        score_q <= '0;
      end else if (selected && score_inc && (score_q != SCORE_MAX)) begin
        score_q <= score_q + 1'b1;
      end else if (selected && score_dec && (score_q != '0)) begin
        score_q <= score_q - 1'b1;
      end
    end

    assign score_all[gi] = score_q;
  end

  always_comb begin
    latched_score = '0;
    for (int i = 0; i < 3; i++) begin
      if (id_q == 2'(i + 1)) begin
        latched_score = score_all[i];
      end
    end
  end

  assign show_id   = (state_q == ST_ANSWER) || (state_q == ST_RESULT);
  assign bs1_value = (state_q == ST_ANSWER) ? timer_q : latched_score;

  seg7_decode u_seg_id (
    .value_i ({2'b00, id_q}),
    .blank_i (!show_id),
    .seg_o   (bs0_d)
  );

  seg7_decode u_seg_value (
    .value_i (bs1_value),
    .blank_i (!show_id),
    .seg_o   (bs1_d)
  );

  // start_q resets high so a button held through reset is not taken as an edge.
  always_ff @(posedge clock_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q    <= ST_IDLE;
      start_q    <= 1'b1;
      id_q       <= '0;
      timer_q    <= '0;
      beep_cnt_q <= '0;
      clear_q    <= 1'b0;
      bs0_q      <= SEG_BLANK;
      bs1_q      <= SEG_BLANK;
    end else begin
      state_q    <= state_d;
      start_q    <= bus.start;
      id_q       <= id_d;
      timer_q    <= timer_d;
      beep_cnt_q <= beep_cnt_d;
      clear_q    <= clear_d;
      bs0_q      <= bs0_d;
      bs1_q      <= bs1_d;
    end
  end

  assign bus.arm   = (state_q == ST_ARMED);
  assign bus.beep  = (state_q == ST_RESULT);
  assign bus.clear = clear_q;
  assign bus.bs0   = bs0_q;
  assign bus.bs1   = bs1_q;

endmodule

// File: tb/tb_quiz_host.sv
// Directed bench for quiz_host: a round-level reference model checked every
// cycle, plus literal digit/buzzer expectations for the key scenarios.
module tb_quiz_host;

  localparam int SECS = 3;
  localparam int BEEP = 5;

  localparam int P_IDLE  = 0;
  localparam int P_ARMED = 1;
  localparam int P_ANS   = 2;
  localparam int P_RES   = 3;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  quiz_host_if bus ();

  quiz_host #(
    .ANSWER_SECS (SECS),
    .BEEP_CYCLES (BEEP)
  ) dut (
    .clock_i  (clk),
    .reset_ni (rst_n),
    .bus      (bus)
  );

  int checks   = 0;
  int failures = 0;
  bit cmp_en   = 1'b0;

  logic [6:0] seg_tab [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                               7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

  // Reference model: game phase, contestant, seconds left, scores, buzzer time.
  int         m_ph;
  int         m_id;
  int         m_timer;
  int         m_beep_left;
  int         m_score [3];
  bit         m_prev_start;
  bit         m_clear;
  logic [6:0] m_bs0;
  logic [6:0] m_bs1;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_ph         = P_IDLE;
    m_id         = 0;
    m_timer      = 0;
    m_beep_left  = 0;
    m_prev_start = 1'b1;
    m_clear      = 1'b0;
    m_bs0        = 7'h7F;
    m_bs1        = 7'h7F;
    for (int i = 0; i < 3; i++) m_score[i] = 0;
  endtask

  task automatic model_step();
    bit s_edge, ok, ng, to;
    if (!rst_n) return;
    s_edge       = bus.start && !m_prev_start;
    m_prev_start = bus.start;
    ok = bus.judge_ok && !bus.judge_ng;
    ng = bus.judge_ng && !bus.judge_ok;
    to = 1'b0;
    m_bs0 = (m_ph == P_ANS || m_ph == P_RES) ? seg_tab[m_id] : 7'h7F;
    if (m_ph == P_ANS)      m_bs1 = seg_tab[m_timer];
    else if (m_ph == P_RES) m_bs1 = seg_tab[m_score[m_id-1]];
    else                    m_bs1 = 7'h7F;
    m_clear = 1'b0;
    case (m_ph)
      P_IDLE: if (s_edge) m_ph = P_ARMED;
      P_ARMED: begin
        if (s_edge) begin
          m_ph = P_IDLE;
          m_clear = 1'b1;
        end else if (bus.chose != 3'b000) begin
          m_id    = bus.chose[0] ? 1 : (bus.chose[1] ? 2 : 3);
          m_timer = SECS;
          m_ph    = P_ANS;
        end
      end
      P_ANS: begin
        if (bus.tick && m_timer > 0) begin
          to = (m_timer == 1);
          m_timer--;
        end
        if (ok) begin
          if (m_score[m_id-1] < 9) m_score[m_id-1]++;
          m_ph = P_RES;
          m_beep_left = BEEP;
        end else if (ng || to) begin
`ifdef QUIZ_PENALTY_EN
          if (m_score[m_id-1] > 0) m_score[m_id-1]--;
`endif
          m_ph = P_RES;
          m_beep_left = BEEP;
        end
      end
      default: begin
        m_beep_left--;
        if (m_beep_left == 0) begin
          m_ph = P_IDLE;
          m_clear = 1'b1;
        end
      end
    endcase
  endtask

  always @(negedge clk) begin
    if (cmp_en && rst_n) begin
      chk("cyc_arm",   8'(bus.arm),   8'(m_ph == P_ARMED));
      chk("cyc_beep",  8'(bus.beep),  8'(m_ph == P_RES));
      chk("cyc_clear", 8'(bus.clear), 8'(m_clear));
      chk("cyc_bs0",   8'(bus.bs0),   8'(m_bs0));
      chk("cyc_bs1",   8'(bus.bs1),   8'(m_bs1));
    end
  end

  task automatic cyc();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic start_pulse();
    bus.start = 1'b1; cyc();
    bus.start = 1'b0; cyc();
  endtask

  task automatic pick(input logic [2:0] c);
    bus.chose = c; cyc();
    bus.chose = 3'b000; cyc();
  endtask

  task automatic verdict(input logic ok, input logic ng);
    bus.judge_ok = ok; bus.judge_ng = ng; cyc();
    bus.judge_ok = 1'b0; bus.judge_ng = 1'b0;
  endtask

  task automatic tick_pulse();
    bus.tick = 1'b1; cyc();
    bus.tick = 1'b0; cyc();
  endtask

  task automatic wait_idle();
    int n = 0;
    while (bus.beep && n < 40) begin
      cyc();
      n++;
    end
    chk("wait_idle_bound", 8'(bus.beep), 8'(0));
    cyc();
  endtask

  initial begin
    int n;
    bus.start = 1'b0; bus.chose = 3'b000; bus.tick = 1'b0;
    bus.judge_ok = 1'b0; bus.judge_ng = 1'b0;
    model_reset();
    #12;
    chk("rst_arm",   8'(bus.arm),   8'(0));
    chk("rst_clear", 8'(bus.clear), 8'(0));
    chk("rst_beep",  8'(bus.beep),  8'(0));
    chk("rst_bs0",   8'(bus.bs0),   8'(7'h7F));
    chk("rst_bs1",   8'(bus.bs1),   8'(7'h7F));
    @(posedge clk); #1;
    rst_n  = 1'b1;
    cmp_en = 1'b1;
    cyc(); cyc();

    // Judge pulses in IDLE are ignored.
    verdict(1'b1, 1'b0); cyc();
    chk("idle_judge_ignored", 8'(bus.beep), 8'(0));

    // Contestant 2 answers correctly.
    start_pulse();
    chk("armed_arm", 8'(bus.arm), 8'(1));
    pick(3'b010);
    chk("ans_bs0_id2",  8'(bus.bs0), 8'(7'h24));
    chk("ans_bs1_secs", 8'(bus.bs1), 8'(7'h30));
    verdict(1'b1, 1'b0);
    n = 0;
    while (bus.beep && n < 20) begin
      n++;
      if (n == 2) chk("res_bs1_score1", 8'(bus.bs1), 8'(7'h79));
      cyc();
    end
    chk("beep_len", 8'(n), 8'(BEEP));
    chk("idle_entry_clear", 8'(bus.clear), 8'(1));
    cyc();
    chk("clear_one_cycle", 8'(bus.clear), 8'(0));

    // Two lockout bits at once: lowest index wins.
    start_pulse();
    pick(3'b011);
    chk("ans_bs0_id1", 8'(bus.bs0), 8'(7'h79));
    verdict(1'b0, 1'b1);
    wait_idle();

    // Timeout with no verdict for contestant 3.
    start_pulse();
    pick(3'b100);
    chk("tmo_bs1_3", 8'(bus.bs1), 8'(7'h30));
    tick_pulse();
    chk("tmo_bs1_2", 8'(bus.bs1), 8'(7'h24));
    tick_pulse();
    chk("tmo_bs1_1", 8'(bus.bs1), 8'(7'h79));
    bus.tick = 1'b1; cyc(); bus.tick = 1'b0;
    chk("tmo_to_result", 8'(bus.beep), 8'(1));
    cyc();
    chk("tmo_score0", 8'(bus.bs1), 8'(7'h40));
    wait_idle();

    // Ten correct answers for contestant 3 saturate at 9.
    for (int k = 1; k <= 10; k++) begin
      start_pulse();
      pick(3'b100);
      verdict(1'b1, 1'b0);
      cyc();
      if (k == 10) chk("score_sat9", 8'(bus.bs1), 8'(7'h10));
      wait_idle();
    end

    // Contradictory verdicts hold ANSWER; a later single ok is taken.
    start_pulse();
    pick(3'b001);
    verdict(1'b1, 1'b1);
    chk("both_held", 8'(bus.beep), 8'(0));
    cyc();
    chk("both_held2", 8'(bus.beep), 8'(0));
    verdict(1'b1, 1'b0);
    chk("ok_after_both", 8'(bus.beep), 8'(1));
    cyc();
    chk("ok_after_both_score", 8'(bus.bs1), 8'(7'h79));
    wait_idle();

    // judge_ok on the same cycle as the timeout tick wins.
    start_pulse();
    pick(3'b010);
    tick_pulse();
    tick_pulse();
    bus.tick = 1'b1; bus.judge_ok = 1'b1; cyc();
    bus.tick = 1'b0; bus.judge_ok = 1'b0;
    chk("ok_vs_timeout", 8'(bus.beep), 8'(1));
    cyc();
    chk("ok_vs_timeout_score", 8'(bus.bs1), 8'(7'h24));
    wait_idle();

    // Start in ARMED aborts even with a contestant locked in.
    start_pulse();
    bus.start = 1'b1; bus.chose = 3'b001; cyc();
    bus.start = 1'b0; bus.chose = 3'b000;
    chk("abort_clear", 8'(bus.clear), 8'(1));
    chk("abort_arm",   8'(bus.arm),   8'(0));
    cyc();

    // Reset while the buzzer sounds, start held high across release.
    start_pulse();
    pick(3'b100);
    verdict(1'b1, 1'b0);
    cyc();
    chk("pre_rst_beep", 8'(bus.beep), 8'(1));
    #2;
    rst_n = 1'b0;
    bus.start = 1'b1;
    model_reset();
    #1;
    chk("midrst_beep", 8'(bus.beep), 8'(0));
    chk("midrst_bs0",  8'(bus.bs0),  8'(7'h7F));
    chk("midrst_bs1",  8'(bus.bs1),  8'(7'h7F));
    cyc(); cyc();
    rst_n = 1'b1;
    cyc(); cyc();
    chk("held_start_no_arm", 8'(bus.arm), 8'(0));
    bus.start = 1'b0; cyc();
    start_pulse();
    pick(3'b100);
    verdict(1'b0, 1'b1);
    cyc();
    chk("score_cleared", 8'(bus.bs1), 8'(7'h40));
    wait_idle();

    cmp_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule
